// File: rtl/seq_pattern_tx_if.sv
// Control/data bundle between a pattern-transmitter client and seq_pattern_tx.
// master = client driving requests; slave = the transmitter.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int GAP_W = 4,
  parameter int REP_W = 8
);
  logic             start;
  logic             stop;
  logic [PAT_W-1:0] pat_in;
  logic [REP_W-1:0] rep_in;
  logic [GAP_W-1:0] gap_in;
  logic             dout;
  logic             dout_vld;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, pat_in, rep_in, gap_in,
    input  dout, dout_vld, busy, done
  );

  modport slave (
    input  start, stop, pat_in, rep_in, gap_in,
    output dout, dout_vld, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB first, with
// programmable repeat count (0 = continuous) and idle gap between repetitions.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int GAP_W = 4,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  seq_pattern_tx_if.slave  bus
);
  localparam int CNT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [GAP_W-1:0] gap_reg_q, gap_reg_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      pat_q     <= '0;
      gap_reg_q <= '0;
      gap_cnt_q <= '0;
      rep_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      pat_q     <= pat_d;
      gap_reg_q <= gap_reg_d;
      gap_cnt_q <= gap_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    gap_reg_d = gap_reg_q;
    gap_cnt_d = gap_cnt_q;
    rep_cnt_d = rep_cnt_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pat_d     = bus.pat_in;
          shreg_d   = bus.pat_in;
          rep_cnt_d = bus.rep_in;
          gap_reg_d = bus.gap_in;
          bit_cnt_d = LAST_BIT;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d   = {shreg_q[PAT_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q - CNT_W'(1);
        if (bit_cnt_q == '0) begin
          // rep_cnt==0 means continuous, so it is held rather than wrapped
          if (rep_cnt_q != '0) rep_cnt_d = rep_cnt_q - REP_W'(1);
          if (rep_cnt_q == REP_W'(1) || bus.stop) begin
            state_d = DONE;
          end else if (gap_reg_q == '0) begin
            shreg_d   = pat_q;
            bit_cnt_d = LAST_BIT;
          end else begin
            gap_cnt_d = gap_reg_q - GAP_W'(1);
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        if (bus.stop) begin
          state_d = DONE;
        end else if (gap_cnt_q == '0) begin
          shreg_d   = pat_q;
          bit_cnt_d = LAST_BIT;
          state_d   = SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registered state, so clr clears them at once
  assign bus.dout     = (state_q == SHIFT) & shreg_q[PAT_W-1];
  assign bus.dout_vld = (state_q == SHIFT);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized bench for seq_pattern_tx against a cycle-trace model built from
// repetitions, gaps and the stop level.
module tb_seq_pattern_tx;
  localparam int PAT_W = 4;
  localparam int GAP_W = 4;
  localparam int REP_W = 8;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .GAP_W(GAP_W), .REP_W(REP_W)) bus ();
  seq_pattern_tx #(.PAT_W(PAT_W), .GAP_W(GAP_W), .REP_W(REP_W)) dut (
    .clk(clk), .clr(clr), .bus(bus.slave)
  );

  int passed = 0;
  int total  = 0;

  // {busy, dout_vld, dout, done} per cycle after the start edge
  logic [3:0] exp_q[$];
  int         det_hits;

  function automatic logic [3:0] obs();
    return {bus.busy, bus.dout_vld, bus.dout, bus.done};
  endfunction

  // Expected trace: cycle k is stop-high when k >= stop_at; stop is judged at
  // the last bit of each pattern and in every gap cycle.
  task automatic build_model(input logic [PAT_W-1:0] pat, input int rep,
                             input int gap, input int stop_at);
    int k = 0;
    int r = 0;
    bit fin = 0;
    exp_q.delete();
    while (!fin) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        exp_q.push_back({1'b1, 1'b1, pat[b], 1'b0});
        k++;
      end
      r++;
      if ((rep != 0 && r == rep) || stop_at <= k - 1) fin = 1;
      else begin
        for (int g = 0; g < gap && !fin; g++) begin
          exp_q.push_back(4'b1000);
          k++;
          if (stop_at <= k - 1) fin = 1;
        end
      end
    end
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b0000);
  endtask

  task automatic run_tx(input string name, input logic [PAT_W-1:0] pat,
                        input int rep, input int gap, input int stop_at,
                        input bit junk);
    logic [3:0] o;
    logic [PAT_W-1:0] sh = '0;
    build_model(pat, rep, gap, stop_at);
    det_hits = 0;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.stop   = (stop_at == 0);
    bus.pat_in = pat;
    bus.rep_in = REP_W'(rep);
    bus.gap_in = GAP_W'(gap);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk); #1;
      bus.stop = (k >= stop_at);
      if (junk && k <= exp_q.size() - 2) begin
        bus.start  = 1'($urandom);
        bus.pat_in = PAT_W'($urandom);
        bus.rep_in = REP_W'($urandom);
        bus.gap_in = GAP_W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      o = obs();
      total++;
      if (o !== exp_q[k]) $display("FAIL %s cycle %0d: got %b want %b", name, k, o, exp_q[k]);
      else passed++;
      if (bus.dout_vld) begin
        sh = {sh[PAT_W-2:0], bus.dout};
        if (sh == 4'b1101) det_hits++;
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.start = 0; bus.stop = 0; bus.pat_in = '0; bus.rep_in = '0; bus.gap_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (obs() !== 4'b0000) $display("FAIL reset: got %b want 0000", obs());
    else passed++;
    // stop alone in IDLE must not start anything
    bus.stop = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (obs() !== 4'b0000) $display("FAIL idle_stop: got %b want 0000", obs());
    else passed++;
    bus.stop = 1'b0;
  endtask

  task automatic test_single_shot();
    run_tx("single", 4'b1101, 1, 0, 1000, 0);
  endtask

  task automatic test_back_to_back();
    run_tx("b2b", 4'b1101, 3, 0, 1000, 0);
    total++;
    if (det_hits !== 3) $display("FAIL b2b_detect: got %0d want 3", det_hits);
    else passed++;
  endtask

  task automatic test_gap();
    run_tx("gap", 4'b1101, 2, 2, 1000, 0);
  endtask

  task automatic test_continuous_stop();
    // stop on 2nd bit of 5th pattern: cycle 4*4+1
    run_tx("cont_stop", 4'b1101, 0, 0, 17, 0);
    total++;
    if (exp_q.size() !== 22) $display("FAIL cont_stop_len: got %0d want 22", exp_q.size());
    else passed++;
    run_tx("start_stop", 4'b1011, 0, 1, 0, 0);
  endtask

  task automatic test_start_while_busy();
    run_tx("busy_junk", 4'b1101, 2, 1, 1000, 1);
  endtask

  task automatic test_clr_mid_shift();
    @(posedge clk); #1;
    bus.start = 1; bus.pat_in = 4'b1111; bus.rep_in = 0; bus.gap_in = 0;
    @(posedge clk); #1 bus.start = 0;
    @(posedge clk); #1;
    total++;
    if (obs() !== 4'b1110) $display("FAIL pre_clr: got %b want 1110", obs());
    else passed++;
    clr = 1'b1;
    #1;
    total++;
    if (obs() !== 4'b0000) $display("FAIL clr_async: got %b want 0000", obs());
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0) $display("FAIL clr_no_done: got %b want 0", bus.done);
      else passed++;
    end
    @(posedge clk); #1 clr = 1'b0;
    run_tx("after_clr", 4'b1001, 2, 0, 1000, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      int rep = $urandom_range(0, 4);
      int gap = $urandom_range(0, 3);
      int sa;
      if (rep == 0 || $urandom_range(0, 1) == 1) sa = $urandom_range(0, 30);
      else sa = 1000;
      run_tx("random", PAT_W'($urandom), rep, gap, sa, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_back_to_back();
    test_gap();
    test_continuous_stop();
    test_start_while_busy();
    test_clr_mid_shift();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
